// File: rtl/regfile_access_ctrl_pkg.sv
// Shared opcode constants, controller state encoding and opcode classification
// helpers for the register-file access controller.
package regfile_access_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LDI   = 6'b010000;
  localparam logic [5:0] OP_LUI   = 6'b010001;
  localparam logic [5:0] OP_LB    = 6'b011010;
  localparam logic [5:0] OP_SW    = 6'b011011;
  localparam logic [5:0] OP_BEQ   = 6'b011110;
  localparam logic [5:0] OP_BLT   = 6'b011111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Branches and stores produce no register result.
  function automatic logic writes_back(input logic [5:0] op);
    return !((op == OP_BEQ) || (op == OP_BLT) || (op == OP_SW));
  endfunction

  // Immediate loads skip the execute unit entirely.
  function automatic logic imm_only(input logic [5:0] op);
    return (op == OP_LDI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/rac_timeout_counter.sv
// Execute-wait counter: held at zero while clear is high, counts while enabled,
// flags the last allowed cycle of the wait window.
module rac_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reg_reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file port initiator: accepts one decoded instruction, sequences the
// exclusive read/write strobes around the execute unit and retires it.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reg_reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       opcode_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs_in,
  input  logic [4:0]       rt_in,
  input  logic [31:0]      imm_in,
  output logic             reg_read,
  output logic             reg_write,
  output logic [5:0]       opcode,
  output logic [4:0]       reg1,
  output logic [4:0]       reg2,
  output logic [4:0]       reg3,
  output logic [31:0]      imm,
  output logic [31:0]      write_data,
  output logic             ex_start,
  input  logic             ex_done,
  input  logic [31:0]      ex_result,
  output logic             instr_done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  logic   tmo_tc;

  // The counter sits at zero outside EXEC, so every EXEC entry starts a fresh window.
  rac_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reg_reset (reg_reset),
    .clear     (state != ST_EXEC),
    .en        (state == ST_EXEC),
    .tc        (tmo_tc)
  );

  assign instr_ready = (state == ST_IDLE) && !reg_reset;

  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) begin
      state       <= ST_IDLE;
      reg_read    <= 1'b0;
      reg_write   <= 1'b0;
      ex_start    <= 1'b0;
      instr_done  <= 1'b0;
      err_timeout <= 1'b0;
      opcode      <= '0;
      reg1        <= '0;
      reg2        <= '0;
      reg3        <= '0;
      imm         <= '0;
      write_data  <= '0;
      retired     <= '0;
    end else begin
      reg_read    <= 1'b0;
      reg_write   <= 1'b0;
      ex_start    <= 1'b0;
      instr_done  <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            opcode   <= opcode_in;
            reg1     <= rd_in;
            reg2     <= rs_in;
            reg3     <= rt_in;
            imm      <= imm_in;
            reg_read <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (imm_only(opcode)) begin
            write_data <= imm;
            reg_write  <= 1'b1;
            state      <= ST_WRITE;
          end else begin
            ex_start <= 1'b1;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // A result arriving on the last counted cycle still wins over the timeout.
          if (ex_done) begin
            write_data <= ex_result;
            if (writes_back(opcode)) begin
              reg_write <= 1'b1;
              state     <= ST_WRITE;
            end else begin
              instr_done <= 1'b1;
              retired    <= retired + 1'b1;
              state      <= ST_DONE;
            end
          end else if (tmo_tc) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          instr_done <= 1'b1;
          retired    <= retired + 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl: stimulus queues expected strobe
// events, a monitor pops and compares them whenever the DUT pulses a strobe.
module tb_regfile_access_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reg_reset = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [5:0]       opcode_in = '0;
  logic [4:0]       rd_in = '0;
  logic [4:0]       rs_in = '0;
  logic [4:0]       rt_in = '0;
  logic [31:0]      imm_in = '0;
  logic             reg_read;
  logic             reg_write;
  logic [5:0]       opcode;
  logic [4:0]       reg1;
  logic [4:0]       reg2;
  logic [4:0]       reg3;
  logic [31:0]      imm;
  logic [31:0]      write_data;
  logic             ex_start;
  logic             ex_done = 1'b0;
  logic [31:0]      ex_result = '0;
  logic             instr_done;
  logic             err_timeout;
  logic [CNT_W-1:0] retired;

  regfile_access_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reg_reset   (reg_reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode_in   (opcode_in),
    .rd_in       (rd_in),
    .rs_in       (rs_in),
    .rt_in       (rt_in),
    .imm_in      (imm_in),
    .reg_read    (reg_read),
    .reg_write   (reg_write),
    .opcode      (opcode),
    .reg1        (reg1),
    .reg2        (reg2),
    .reg3        (reg3),
    .imm         (imm),
    .write_data  (write_data),
    .ex_start    (ex_start),
    .ex_done     (ex_done),
    .ex_result   (ex_result),
    .instr_done  (instr_done),
    .err_timeout (err_timeout),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_READ, K_START, K_WRITE, K_DONE, K_TMO} kind_e;
  typedef struct {
    kind_e            kind;
    int               cyc;
    logic [5:0]       op;
    logic [4:0]       r1;
    logic [4:0]       r2;
    logic [4:0]       r3;
    logic [31:0]      val;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             q[$];
  int               n_tests = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input kind_e k, input int c, input logic [5:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] r3, input logic [31:0] v,
                      input logic [CNT_W-1:0] ret);
    exp_t e;
    e.kind = k; e.cyc = c; e.op = op; e.r1 = r1; e.r2 = r2; e.r3 = r3; e.val = v; e.ret = ret;
    q.push_back(e);
  endtask

  task automatic pop(input kind_e k);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s @cycle %0d: strobe seen, none expected", k.name(), cyc);
      return;
    end
    e = q.pop_front();
    chk({"kind_", k.name()}, 64'(int'(k)), 64'(int'(e.kind)));
    chk({"cycle_", k.name()}, 64'(cyc), 64'(e.cyc));
    chk({"ready_", k.name()}, 64'(instr_ready), (k == K_TMO) ? 64'd1 : 64'd0);
    case (k)
      K_READ: begin
        chk("read_opcode", 64'(opcode), 64'(e.op));
        chk("read_regs", 64'({reg1, reg2, reg3}), 64'({e.r1, e.r2, e.r3}));
        chk("read_imm", 64'(imm), 64'(e.val));
      end
      K_WRITE: begin
        chk("write_opcode", 64'(opcode), 64'(e.op));
        chk("write_reg1", 64'(reg1), 64'(e.r1));
        chk("write_data", 64'(write_data), 64'(e.val));
      end
      K_DONE, K_TMO: chk({"retired_", k.name()}, 64'(retired), 64'(e.ret));
      default: ;
    endcase
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("strobe_excl", 64'(reg_read && reg_write), 64'd0);
      if (reg_read)    pop(K_READ);
      if (ex_start)    pop(K_START);
      if (reg_write)   pop(K_WRITE);
      if (instr_done)  pop(K_DONE);
      if (err_timeout) pop(K_TMO);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  // mode: 0 normal completion, 1 execute timeout, 2 aborted by reset during EXEC
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [31:0] iv, input int d,
                      input logic [31:0] res, input int mode, input bit hold_valid);
    int n;
    int a;
    bit is_imm;
    bit no_wb;
    is_imm = (op == 6'b010000) || (op == 6'b010001);
    no_wb  = (op == 6'b011110) || (op == 6'b011111) || (op == 6'b011011);
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_wait @cycle %0d: instr_ready=0, expected 1 within 50 cycles", cyc);
      return;
    end
    a = cyc + 1;
    push(K_READ, a, op, rd, rs, rt, iv, '0);
    if (is_imm) begin
      push(K_WRITE, a + 1, op, rd, rs, rt, iv, '0);
      exp_ret++;
      push(K_DONE, a + 2, op, rd, rs, rt, '0, exp_ret);
    end else begin
      push(K_START, a + 1, op, rd, rs, rt, '0, '0);
      if (mode == 1) begin
        push(K_TMO, a + 1 + TIMEOUT, op, rd, rs, rt, '0, exp_ret);
      end else if (mode == 0) begin
        exp_ret++;
        if (!no_wb) begin
          push(K_WRITE, a + 2 + d, op, rd, rs, rt, res, '0);
          push(K_DONE, a + 3 + d, op, rd, rs, rt, '0, exp_ret);
        end else begin
          push(K_DONE, a + 2 + d, op, rd, rs, rt, '0, exp_ret);
        end
      end
    end
    instr_valid = 1'b1;
    opcode_in = op; rd_in = rd; rs_in = rs; rt_in = rt; imm_in = iv;
    @(negedge clk);
    if (!hold_valid) instr_valid = 1'b0;
    if (!is_imm && mode == 0) begin
      repeat (1 + d) @(negedge clk);
      ex_done = 1'b1;
      ex_result = res;
      @(negedge clk);
      ex_done = 1'b0;
    end
  endtask

  initial begin
    #1;
    chk("reset_ready", 64'(instr_ready), 64'd0);
    chk("reset_strobes", 64'({reg_read, reg_write, ex_start, instr_done, err_timeout}), 64'd0);
    chk("reset_fields", 64'({opcode, reg1, reg2, reg3}), 64'd0);
    chk("reset_data", {imm, write_data}, 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    repeat (2) @(negedge clk);
    reg_reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(instr_ready), 64'd1);
    @(negedge clk);

    send(6'b010000, 5'd3, 5'd0, 5'd0, 32'h0000_1234, 0, '0, 0, 1'b0);          // LDI
    send(6'b000000, 5'd5, 5'd1, 5'd2, 32'h0, 3, 32'hDEAD_BEEF, 0, 1'b0);       // R-type
    send(6'b011110, 5'd7, 5'd8, 5'd9, 32'h0000_0010, 0, 32'h0000_0001, 0, 1'b0); // BEQ
    send(6'b011010, 5'd10, 5'd11, 5'd0, 32'hFFFF_FFFC, 1, 32'hFFFF_FF80, 0, 1'b0); // LB
    send(6'b011011, 5'd12, 5'd13, 5'd14, 32'h0000_0008, 2, 32'h5555_AAAA, 0, 1'b0); // SW
    send(6'b000000, 5'd15, 5'd16, 5'd17, 32'h0, 0, '0, 1, 1'b0);               // timeout
    send(6'b000000, 5'd18, 5'd19, 5'd20, 32'h0000_00FF, 0, '0, 2, 1'b0);       // aborted

    // Assert reset two cycles into EXEC; outputs must clear without a clock edge.
    repeat (2) @(negedge clk);
    reg_reset = 1'b1;
    #1;
    exp_ret = '0;
    chk("abort_ready", 64'(instr_ready), 64'd0);
    chk("abort_strobes", 64'({reg_read, reg_write, ex_start, instr_done, err_timeout}), 64'd0);
    chk("abort_fields", 64'({opcode, reg1, reg2, reg3}), 64'd0);
    chk("abort_data", {imm, write_data}, 64'd0);
    chk("abort_retired", 64'(retired), 64'd0);
    chk("abort_queue", 64'(q.size()), 64'd0);
    @(negedge clk);
    reg_reset = 1'b0;
    @(negedge clk);
    ex_done = 1'b1;
    ex_result = 32'hBAD0_BAD0;
    @(negedge clk);
    ex_done = 1'b0;
    @(negedge clk);
    send(6'b010001, 5'd21, 5'd0, 5'd0, 32'hABCD_0000, 0, '0, 0, 1'b0);         // LUI

    repeat (4) @(negedge clk);
    reg_reset = 1'b1;
    exp_ret = '0;
    @(negedge clk);
    reg_reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      send(6'b010000, 5'(i), 5'd0, 5'd0, 32'(i) * 32'h111, 0, '0, 0, 1'b1);
    end
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("burst_retired_wrap", 64'(retired), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Initiator side of the register-file port. Accepts one decoded instruction at a time over a valid/ready handshake and sequences the register file's mutually exclusive read and write strobes. Launches the execute unit and waits for its result, then issues the write-back. Sits between the decode stage and the register file / ALU, and guarantees reg_read and reg_write are never high together.

Parameters:
TIMEOUT, 64, max cycles to wait for ex_done before aborting (must be >= 2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reg_reset  in  1  reset, asynchronous, active-high
instr_valid  in  1  decode presents an instruction
instr_ready  out  1  controller can accept (high only in IDLE, low while reg_reset high)
opcode_in  in  6  instruction opcode
rd_in / rs_in / rt_in  in  5 each  register fields (reg1/reg2/reg3 order)
imm_in  in  32  sign-extended immediate
reg_read  out  1  register-file read strobe
reg_write  out  1  register-file write strobe
opcode  out  6  latched opcode to register file
reg1 / reg2 / reg3  out  5 each  latched register fields
imm  out  32  latched immediate
write_data  out  32  write-back value
ex_start  out  1  one-cycle pulse launching the execute unit
ex_done  in  1  execute result valid, single cycle
ex_result  in  32  execute result
instr_done  out  1  one-cycle pulse on retire
err_timeout  out  1  one-cycle pulse on execute timeout
retired  out  CNT_W  count of retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset (async): state IDLE; all outputs 0, including latched fields, write_data, and retired. Reset mid-operation drops to IDLE immediately; strobes fall in the same instant.
- States: IDLE, READ, EXEC, WRITE, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at a rising edge: latch opcode, fields, and imm; go to READ.
- READ:
  - reg_read=1 for exactly 1 cycle.
  - If opcode is LDI (010000) or LUI (010001): write_data<=imm, go to WRITE.
  - Otherwise go to EXEC.
- EXEC:
  - ex_start=1 in the first EXEC cycle only.
  - A wait counter starts at 0 on entry.
  - ex_done high: latch ex_result into write_data. Then go to WRITE if the opcode writes back, otherwise DONE.
  - ex_done is honoured in the same cycle as ex_start.
  - Counter reaches TIMEOUT-1 without ex_done: pulse err_timeout, go to IDLE. Nothing is written; instruction is not retired.
- Write-back rule: no write for BEQ/BLT (opcode[5:1]==01111) or SW (011011); all other opcodes write.
- WRITE:
  - reg_write=1 for exactly 1 cycle.
  - opcode, reg1, and write_data are held stable through that cycle.
  - Partial-width merging (LDI/LUI/LB) is done by the register file, not here.
  - Then go to DONE.
- DONE: instr_done=1 for 1 cycle; retired+1 (wraps); go to IDLE.
- Latched outputs stay stable from READ until the next accept.
- Throughput: at most one instruction per 4 cycles. Minimum LDI/LUI latency from accept to instr_done is 3 cycles.
- ex_done outside EXEC is ignored.
- Invariant: !(reg_read && reg_write) at all times.

Decomposition:
- Shared package:
  - opcode constants OP_RTYPE=000000, OP_LDI, OP_LUI, OP_LB=011010, OP_SW, OP_BEQ=011110, OP_BLT=011111.
  - State enum.
  - Function writes_back(opcode) and function imm_only(opcode).
- One natural sub-module: rac_timeout_counter (load/clear, terminal-count flag). The FSM stays in the top module.

Test Plan:
- LDI rd=3 imm=0x0000_1234 → reg_read pulse one cycle after accept; reg_write with write_data=0x1234 and reg1=3 on the next cycle; instr_done next; ex_start never asserted; retired=1.
- R-type opcode=000000 rd=5 rs=1 rt=2, ex_done after 3 cycles with 0xDEAD_BEEF → ex_start single pulse; write_data=0xDEADBEEF during reg_write; instr_done follows.
- BEQ opcode=011110, ex_done=1 immediately → no reg_write ever; instr_done 1 cycle after ex_done; retired increments.
- TIMEOUT=8, R-type with ex_done never asserted → err_timeout pulses 8 cycles after EXEC entry; no reg_write; retired unchanged; instr_ready=1 next cycle.
- reg_reset pulsed mid-EXEC → all outputs 0 asynchronously; a late ex_done is ignored; a new LUI is accepted cleanly after release.
- CNT_W=4, 17 back-to-back LDIs with instr_valid held high → retired=1 after wrap; instr_ready low in every non-IDLE cycle; strobe mutual exclusion holds throughout.
